// File: rtl/membus_arbiter.sv
// rtl/membus_arbiter.sv - N-master to 1-slave Membus arbiter with in-order response routing
module membus_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RR_MODE         = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_MASTERS-1:0]                 m_valid,
    output logic [NUM_MASTERS-1:0]                 m_ready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]      m_addr,
    input  logic [NUM_MASTERS-1:0]                 m_wen,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      m_wdata,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]    m_wmask,
    output logic [NUM_MASTERS-1:0]                 m_rvalid,
    output logic [DATA_WIDTH-1:0]                  m_rdata,
    output logic                                   s_valid,
    input  logic                                   s_ready,
    output logic [ADDR_WIDTH-1:0]                  s_addr,
    output logic                                   s_wen,
    output logic [DATA_WIDTH-1:0]                  s_wdata,
    output logic [DATA_WIDTH/8-1:0]                s_wmask,
    input  logic                                   s_rvalid,
    input  logic [DATA_WIDTH-1:0]                  s_rdata,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   err_orphan
);
    localparam int MASK_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);

    logic [IDX_W-1:0] id_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] rr_ptr;
    logic             err_q;

    logic [IDX_W-1:0] win;
    logic             found;
    int               idx;
    logic             any_valid;
    logic             can_issue;
    logic             accept;
    logic             pop;
    logic             orphan;
    logic [IDX_W-1:0] head;

    assign any_valid = |m_valid;
    // A response popping this cycle frees a slot for a same-cycle issue.
    assign can_issue = (count < CNT_MAX) || (s_rvalid && (count != '0));
    assign s_valid   = rst && any_valid && can_issue;
    assign accept    = s_valid && s_ready;
    assign pop       = rst && s_rvalid && (count != '0);
    assign orphan    = s_rvalid && (count == '0);
    assign head      = id_mem[rd_ptr];

    // Fixed priority is the round-robin scan with the start pinned to 0.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = k + ((RR_MODE != 0) ? int'(rr_ptr) : 0);
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && m_valid[idx]) begin
                win   = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        s_addr  = '0;
        s_wen   = 1'b0;
        s_wdata = '0;
        s_wmask = '0;
        if (s_valid) begin
            s_addr  = m_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
            s_wen   = m_wen[win];
            s_wdata = m_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            s_wmask = m_wmask[int'(win)*MASK_W +: MASK_W];
        end
    end

    always_comb begin
        m_ready = '0;
        if (accept) m_ready[win] = 1'b1;
    end

    always_comb begin
        m_rvalid = '0;
        if (pop) m_rvalid[head] = 1'b1;
    end

    assign m_rdata     = s_rdata;
    assign outstanding = count;
    assign err_orphan  = err_q;

    always_ff @(posedge clk) begin
        if (accept) id_mem[wr_ptr] <= win;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
                if (RR_MODE != 0) rr_ptr <= (win == IDX_LAST) ? '0 : win + IDX_W'(1);
            end
            if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (orphan) err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_membus_arbiter.sv
// tb/tb_membus_arbiter.sv - scoreboard bench: round-robin and fixed-priority arbiters on shared stimulus
module tb_membus_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_valid;
    logic [N*AW-1:0] m_addr;
    logic [N-1:0]    m_wen;
    logic [N*DW-1:0] m_wdata;
    logic [N*MW-1:0] m_wmask;
    logic            s_ready;
    logic            s_rvalid;
    logic [DW-1:0]   s_rdata;

    logic [N-1:0]  mr_a, rv_a, mr_b, rv_b;
    logic [DW-1:0] rd_a, rd_b, sd_a, sd_b;
    logic          sv_a, sv_b, sw_a, sw_b, err_a, err_b;
    logic [AW-1:0] sa_a, sa_b;
    logic [MW-1:0] sm_a, sm_b;
    logic [1:0]    out_a, out_b;

    int n_cmp = 0;
    int n_err = 0;
    int exp_ga[$];
    int exp_gb[$];
    logic [N+DW-1:0] exp_ra[$];
    logic [N+DW-1:0] exp_rb[$];

    always #5 clk = ~clk;

    membus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .MAX_OUTSTANDING(3), .RR_MODE(1)) dut_a (
        .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(mr_a), .m_addr(m_addr),
        .m_wen(m_wen), .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rvalid(rv_a),
        .m_rdata(rd_a), .s_valid(sv_a), .s_ready(s_ready), .s_addr(sa_a),
        .s_wen(sw_a), .s_wdata(sd_a), .s_wmask(sm_a), .s_rvalid(s_rvalid),
        .s_rdata(s_rdata), .outstanding(out_a), .err_orphan(err_a));

    membus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .MAX_OUTSTANDING(3), .RR_MODE(0)) dut_b (
        .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(mr_b), .m_addr(m_addr),
        .m_wen(m_wen), .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rvalid(rv_b),
        .m_rdata(rd_b), .s_valid(sv_b), .s_ready(s_ready), .s_addr(sa_b),
        .s_wen(sw_b), .s_wdata(sd_b), .s_wmask(sm_b), .s_rvalid(s_rvalid),
        .s_rdata(s_rdata), .outstanding(out_b), .err_orphan(err_b));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic gnt(input int a, input int b);
        exp_ga.push_back(a);
        exp_gb.push_back(b);
    endtask

    task automatic rsp(input int a, input int b, input logic [DW-1:0] d);
        logic [N-1:0] oa, ob;
        oa = '0;
        ob = '0;
        oa[a] = 1'b1;
        ob[b] = 1'b1;
        exp_ra.push_back({oa, d});
        exp_rb.push_back({ob, d});
    endtask

    task automatic step(input logic [N-1:0] v, input logic rdy, input logic rv, input logic [DW-1:0] d);
        m_valid  = v;
        s_ready  = rdy;
        s_rvalid = rv;
        s_rdata  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [1:0] e);
        check({name, "_a"}, 64'(out_a), 64'(e));
        check({name, "_b"}, 64'(out_b), 64'(e));
    endtask

    task automatic check_grant(input string name, input logic [N-1:0] mr, input logic [AW-1:0] sa,
                               input logic sw, input logic [DW-1:0] sd, input logic [MW-1:0] sm,
                               input int e);
        logic [N-1:0] oh;
        oh = '0;
        oh[e] = 1'b1;
        check({name, "_ready"}, 64'(mr), 64'(oh));
        check({name, "_addr"},  64'(sa), 64'(m_addr[e*AW +: AW]));
        check({name, "_wen"},   64'(sw), 64'(m_wen[e]));
        check({name, "_wdata"}, 64'(sd), 64'(m_wdata[e*DW +: DW]));
        check({name, "_wmask"}, 64'(sm), 64'(m_wmask[e*MW +: MW]));
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (sv_a && s_ready) begin
                if (exp_ga.size() == 0) check("grant_a_unexpected", 64'(mr_a), 64'd0);
                else check_grant("grant_a", mr_a, sa_a, sw_a, sd_a, sm_a, exp_ga.pop_front());
            end
            if (sv_b && s_ready) begin
                if (exp_gb.size() == 0) check("grant_b_unexpected", 64'(mr_b), 64'd0);
                else check_grant("grant_b", mr_b, sa_b, sw_b, sd_b, sm_b, exp_gb.pop_front());
            end
            if (rv_a != '0) begin
                if (exp_ra.size() == 0) check("resp_a_unexpected", 64'(rv_a), 64'd0);
                else check("resp_a", 64'({rv_a, rd_a}), 64'(exp_ra.pop_front()));
            end
            if (rv_b != '0) begin
                if (exp_rb.size() == 0) check("resp_b_unexpected", 64'(rv_b), 64'd0);
                else check("resp_b", 64'({rv_b, rd_b}), 64'(exp_rb.pop_front()));
            end
        end
    end

    initial begin
        m_addr   = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        m_wdata  = {32'h0000_00D2, 32'h0000_00D1, 32'h0000_00D0};
        m_wmask  = {4'hC, 4'h3, 4'hF};
        m_wen    = 3'b001;
        rst      = 1'b0;
        m_valid  = 3'b111;
        s_ready  = 1'b1;
        s_rvalid = 1'b1;
        s_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_valid", 64'({sv_a, sv_b}), 64'd0);
        check("rst_m_ready", 64'({mr_a, mr_b}), 64'd0);
        check("rst_m_rvalid", 64'({rv_a, rv_b}), 64'd0);
        check("rst_err", 64'({err_a, err_b}), 64'd0);
        check_out("rst_outstanding", 2'd0);
        m_valid  = 3'b000;
        s_rvalid = 1'b0;
        rst      = 1'b1;

        // All masters valid, single-cycle responder.
        gnt(0, 0);
        step(3'b111, 1'b1, 1'b0, 32'h0);
        check_out("t1_out_first", 2'd1);
        for (int k = 1; k < 6; k++) begin
            gnt(k % 3, 0);
            rsp((k - 1) % 3, 0, 32'h100 + 32'(k - 1));
            step(3'b111, 1'b1, 1'b1, 32'h100 + 32'(k - 1));
            check_out("t1_out_steady", 2'd1);
        end
        rsp(2, 0, 32'h105);
        step(3'b000, 1'b1, 1'b1, 32'h105);
        check_out("t1_out_drained", 2'd0);

        // Fill to MAX_OUTSTANDING, then a pop frees a slot in the same cycle.
        for (int k = 0; k < 3; k++) begin
            gnt(1, 1);
            step(3'b010, 1'b1, 1'b0, 32'h0);
        end
        check_out("t2_out_full", 2'd3);
        m_valid = 3'b010;
        #1;
        check("t2_full_s_valid", 64'({sv_a, sv_b}), 64'd0);
        check("t2_full_m_ready", 64'({mr_a, mr_b}), 64'd0);
        step(3'b010, 1'b1, 1'b0, 32'h0);
        check_out("t2_out_stall", 2'd3);
        gnt(1, 1);
        rsp(1, 1, 32'hDEAD);
        step(3'b010, 1'b1, 1'b1, 32'hDEAD);
        check_out("t2_out_swap", 2'd3);
        for (int k = 1; k <= 3; k++) begin
            rsp(1, 1, 32'hA0 + 32'(k));
            step(3'b000, 1'b1, 1'b1, 32'hA0 + 32'(k));
        end
        check_out("t2_out_drained", 2'd0);

        // Stalled slave: no acceptance, pointer must not move.
        m_valid = 3'b111;
        s_ready = 1'b0;
        #1;
        check("t3_stall_s_valid", 64'({sv_a, sv_b}), 64'd3);
        check("t3_stall_m_ready", 64'({mr_a, mr_b}), 64'd0);
        check("t3_stall_rr_addr", 64'(sa_a), 64'h3000);
        @(posedge clk);
        #1;
        // Master 2 read then master 0 write, delayed responses.
        gnt(2, 2);
        step(3'b100, 1'b1, 1'b0, 32'h0);
        gnt(0, 0);
        step(3'b001, 1'b1, 1'b0, 32'h0);
        check_out("t3_out_two", 2'd2);
        repeat (4) step(3'b000, 1'b1, 1'b0, 32'h0);
        check("t3_idle_payload", 64'({sa_a, sd_a}), 64'd0);
        rsp(2, 2, 32'h22);
        step(3'b000, 1'b1, 1'b1, 32'h22);
        rsp(0, 0, 32'h77);
        step(3'b000, 1'b1, 1'b1, 32'h77);
        check_out("t3_out_drained", 2'd0);

        // Orphan response.
        m_valid  = 3'b000;
        s_rvalid = 1'b1;
        s_rdata  = 32'h55;
        #1;
        check("t4_orphan_rvalid", 64'({rv_a, rv_b}), 64'd0);
        @(posedge clk);
        #1;
        check("t4_err_set", 64'({err_a, err_b}), 64'd3);
        check_out("t4_out_zero", 2'd0);
        repeat (2) step(3'b000, 1'b1, 1'b0, 32'h0);
        check("t4_err_sticky", 64'({err_a, err_b}), 64'd3);

        // Asynchronous reset with two requests in flight.
        for (int k = 0; k < 2; k++) begin
            gnt(1, 1);
            step(3'b010, 1'b1, 1'b0, 32'h0);
        end
        check_out("t5_out_two", 2'd2);
        m_valid = 3'b111;
        #2;
        rst = 1'b0;
        #1;
        check_out("t5_async_out", 2'd0);
        check("t5_async_err", 64'({err_a, err_b}), 64'd0);
        check("t5_async_s_valid", 64'({sv_a, sv_b}), 64'd0);
        check("t5_async_m_ready", 64'({mr_a, mr_b}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        gnt(0, 0);
        step(3'b111, 1'b1, 1'b0, 32'h0);
        rsp(0, 0, 32'h99);
        step(3'b000, 1'b1, 1'b1, 32'h99);
        check("t5_err_clear", 64'({err_a, err_b}), 64'd0);
        step(3'b000, 1'b1, 1'b1, 32'h5A);
        check("t5_err_post_reset", 64'({err_a, err_b}), 64'd3);
        check_out("t5_out_final", 2'd0);

        step(3'b000, 1'b1, 1'b0, 32'h0);
        check("left_grant_a", 64'(exp_ga.size()), 64'd0);
        check("left_grant_b", 64'(exp_gb.size()), 64'd0);
        check("left_resp_a", 64'(exp_ra.size()), 64'd0);
        check("left_resp_b", 64'(exp_rb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
